// File: rtl/regfile_sb_pkg.sv
// Shared register-file definitions for the decode/writeback path.
// Holds the default architectural port counts, the register address type,
// the scoreboard counter width/type and a small helper for counter limits.
package regfile_sb_pkg;

  localparam int AREG_NREG        = 32;
  localparam int AREG_READ_PORTS  = 2;
  localparam int AREG_WRITE_PORTS = 2;
  localparam int SB_CNT_WIDTH     = 2;

  localparam int CREG_AW = $clog2(AREG_NREG);

  typedef logic [CREG_AW-1:0]      creg_addr_t;
  typedef logic [SB_CNT_WIDTH-1:0] sb_cnt_t;

  // Largest value a pending-writer counter of the given width can hold.
  function automatic int cnt_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/regfile_sb_cnt.sv
// Pending-writer counter for one architectural register.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   flush       clears the count at the next edge
//   inc         number of issues accepted for this register this cycle
//   dec         number of valid writebacks to this register this cycle
//   cnt         current pending count
//   busy        cnt != 0
// The count saturates at 0 (a write to an idle register is legal) and at
// its maximum (never reached while issue is gated by iss_ready).
module regfile_sb_cnt
  import regfile_sb_pkg::*;
#(
  parameter int CNT_WIDTH = SB_CNT_WIDTH,
  parameter int INC_W     = 1,
  parameter int DEC_W     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [INC_W-1:0]     inc,
  input  logic [DEC_W-1:0]     dec,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 busy
);

  localparam int CNT_MAX = cnt_max(CNT_WIDTH);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_next;
  int                   w_net;

  always_comb begin
    w_net = int'(r_cnt) + int'(inc) - int'(dec);
    if (w_net < 0) begin
      w_net = 0;
    end else if (w_net > CNT_MAX) begin
      w_net = CNT_MAX;
    end
    w_next = w_net[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_next;
    end
  end

  assign cnt  = r_cnt;
  assign busy = (r_cnt != '0);

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with same-cycle write-to-read bypass and
// a per-register pending-writer scoreboard.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ra1/ra2  [READ_PORTS]   read addresses; rd1/rd2 read data
//   rbusy1/rbusy2           source register still has an outstanding writer
//   wa/wvalid/wd [WRITE_PORTS] writeback address, enable, data
//   iss_valid/iss_addr [ISSUE_PORTS] destination issue; iss_ready accept
//   flush               clears every pending counter
// Register 0 reads as zero, is never written and is never busy.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int NREG        = AREG_NREG,
  parameter int DATA_WIDTH  = 64,
  parameter int READ_PORTS  = AREG_READ_PORTS,
  parameter int WRITE_PORTS = AREG_WRITE_PORTS,
  parameter int ISSUE_PORTS = 1,
  parameter int CNT_WIDTH   = SB_CNT_WIDTH,
  parameter int BYPASS      = 1,
  localparam int AW         = $clog2(NREG)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [READ_PORTS-1:0][AW-1:0]          ra1,
  input  logic [READ_PORTS-1:0][AW-1:0]          ra2,
  output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  rd1,
  output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  rd2,
  output logic [READ_PORTS-1:0]                  rbusy1,
  output logic [READ_PORTS-1:0]                  rbusy2,
  input  logic [WRITE_PORTS-1:0][AW-1:0]         wa,
  input  logic [WRITE_PORTS-1:0]                 wvalid,
  input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] wd,
  input  logic [ISSUE_PORTS-1:0]                 iss_valid,
  input  logic [ISSUE_PORTS-1:0][AW-1:0]         iss_addr,
  output logic [ISSUE_PORTS-1:0]                 iss_ready,
  input  logic                                   flush
);

  localparam int INC_W   = $clog2(ISSUE_PORTS + 1);
  localparam int DEC_W   = $clog2(WRITE_PORTS + 1);
  localparam int CNT_MAX = cnt_max(CNT_WIDTH);

  logic [DATA_WIDTH-1:0] r_regs    [NREG];
  logic [NREG-1:0]       w_wr_en;
  logic [DATA_WIDTH-1:0] w_wr_data [NREG];
  logic [DEC_W-1:0]      w_wr_cnt  [NREG];
  logic [INC_W-1:0]      w_iss_cnt [NREG];
  logic [CNT_WIDTH-1:0]  w_cnt     [NREG];
  logic [NREG-1:0]       w_busy;

  // Write merge: iterating ports upward lets the highest-index port win.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      w_wr_en[r]   = 1'b0;
      w_wr_data[r] = '0;
      w_wr_cnt[r]  = '0;
    end
    for (int j = 0; j < WRITE_PORTS; j++) begin
      if (wvalid[j]) begin
        w_wr_en[wa[j]]   = 1'b1;
        w_wr_data[wa[j]] = wd[j];
        w_wr_cnt[wa[j]]  = w_wr_cnt[wa[j]] + DEC_W'(1);
      end
    end
  end

  // Ready leaves headroom for every issue port hitting the same register.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      w_iss_cnt[r] = '0;
    end
    for (int k = 0; k < ISSUE_PORTS; k++) begin
      iss_ready[k] = !flush && (int'(w_cnt[iss_addr[k]]) <= CNT_MAX - ISSUE_PORTS);
      if (iss_valid[k] && iss_ready[k]) begin
        w_iss_cnt[iss_addr[k]] = w_iss_cnt[iss_addr[k]] + INC_W'(1);
      end
    end
  end

  assign w_cnt[0]  = '0;
  assign w_busy[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    regfile_sb_cnt #(
      .CNT_WIDTH (CNT_WIDTH),
      .INC_W     (INC_W),
      .DEC_W     (DEC_W)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .inc   (w_iss_cnt[r]),
      .dec   (w_wr_cnt[r]),
      .cnt   (w_cnt[r]),
      .busy  (w_busy[r])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        r_regs[r] <= '0;
      end
    end else begin
      r_regs[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (w_wr_en[r]) begin
          r_regs[r] <= w_wr_data[r];
        end
      end
    end
  end

  // With bypass, a source is busy only if writers remain after this
  // cycle's writebacks retire (cnt minus same-cycle writes, floored at 0).
  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      rd1[p] = r_regs[ra1[p]];
      rd2[p] = r_regs[ra2[p]];
      if (BYPASS != 0) begin
        if (ra1[p] != '0 && w_wr_en[ra1[p]]) rd1[p] = w_wr_data[ra1[p]];
        if (ra2[p] != '0 && w_wr_en[ra2[p]]) rd2[p] = w_wr_data[ra2[p]];
        rbusy1[p] = w_busy[ra1[p]] && (int'(w_cnt[ra1[p]]) > int'(w_wr_cnt[ra1[p]]));
        rbusy2[p] = w_busy[ra2[p]] && (int'(w_cnt[ra2[p]]) > int'(w_wr_cnt[ra2[p]]));
      end else begin
        rbusy1[p] = w_busy[ra1[p]];
        rbusy2[p] = w_busy[ra2[p]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (bypass on / off) share stimulus and
// are compared every cycle against an array-based reference model, plus
// directed scenarios with literal expectations.
module tb_regfile_sb;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0][4:0]  ra1, ra2, wa;
  logic [1:0]       wvalid;
  logic [1:0][63:0] wd;
  logic [0:0]       iss_valid;
  logic [0:0][4:0]  iss_addr;
  logic             flush;

  logic [1:0][63:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic [1:0]       rbusy1_b, rbusy2_b, rbusy1_n, rbusy2_n;
  logic [0:0]       iss_ready_b, iss_ready_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_sb #(.BYPASS(1)) u_dut_b (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .rbusy1(rbusy1_b), .rbusy2(rbusy2_b), .wa(wa), .wvalid(wvalid), .wd(wd),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready_b), .flush(flush)
  );

  regfile_sb #(.BYPASS(0)) u_dut_n (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
    .rbusy1(rbusy1_n), .rbusy2(rbusy2_n), .wa(wa), .wvalid(wvalid), .wd(wd),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready_n), .flush(flush)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_regs [32];
  int          m_cnt  [32];
  bit          m_valid = 1'b0;

  function automatic int nwr(input logic [4:0] a);
    int n = 0;
    for (int j = 0; j < 2; j++) if (wvalid[j] && wa[j] == a) n++;
    return n;
  endfunction

  function automatic logic [63:0] last_wd(input logic [4:0] a);
    logic [63:0] d = '0;
    for (int j = 0; j < 2; j++) if (wvalid[j] && wa[j] == a) d = wd[j];
    return d;
  endfunction

  function automatic logic [63:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && nwr(a) > 0) return last_wd(a);
    return m_regs[a];
  endfunction

  function automatic logic [63:0] exp_busy(input logic [4:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp) return (m_cnt[a] - nwr(a) > 0) ? 64'd1 : 64'd0;
    return (m_cnt[a] != 0) ? 64'd1 : 64'd0;
  endfunction

  function automatic bit exp_ready(input logic [4:0] a);
    return !flush && (m_cnt[a] <= 3 - 1);
  endfunction

  always @(posedge clk) begin
    int nc [32];
    bit fire;
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[r] = '0;
        m_cnt[r]  = 0;
      end
      m_valid = 1'b1;
    end else if (m_valid) begin
      fire = iss_valid[0] && exp_ready(iss_addr[0]);
      for (int r = 1; r < 32; r++) begin
        nc[r] = m_cnt[r] + ((fire && iss_addr[0] == r) ? 1 : 0) - nwr(5'(r));
        if (nc[r] < 0) nc[r] = 0;
        if (flush) nc[r] = 0;
      end
      for (int r = 1; r < 32; r++) begin
        if (nwr(5'(r)) > 0) m_regs[r] = last_wd(5'(r));
        m_cnt[r] = nc[r];
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int p = 0; p < 2; p++) begin
        chk("mdl_rd1_b",   rd1_b[p],    exp_rd(ra1[p], 1'b1));
        chk("mdl_rd2_b",   rd2_b[p],    exp_rd(ra2[p], 1'b1));
        chk("mdl_rd1_n",   rd1_n[p],    exp_rd(ra1[p], 1'b0));
        chk("mdl_rd2_n",   rd2_n[p],    exp_rd(ra2[p], 1'b0));
        chk("mdl_busy1_b", rbusy1_b[p], exp_busy(ra1[p], 1'b1));
        chk("mdl_busy2_b", rbusy2_b[p], exp_busy(ra2[p], 1'b1));
        chk("mdl_busy1_n", rbusy1_n[p], exp_busy(ra1[p], 1'b0));
        chk("mdl_busy2_n", rbusy2_n[p], exp_busy(ra2[p], 1'b0));
      end
      chk("mdl_ready_b", iss_ready_b[0], 64'(exp_ready(iss_addr[0])));
      chk("mdl_ready_n", iss_ready_n[0], 64'(exp_ready(iss_addr[0])));
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; wvalid = '0; iss_valid = '0;
    wa = '0; wd = '0; iss_addr = '0; ra1 = '0; ra2 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ra1[0] = 5; ra1[1] = 0; ra2[0] = 7; ra2[1] = 3; iss_addr[0] = 3;
    @(negedge clk);
    chk("rst_rd", rd1_b[0], 0);
    chk("rst_busy", rbusy2_b[1], 0);
    chk("rst_ready", iss_ready_b[0], 1);

    // write r5 on port 0
    next_cyc(); wvalid = 2'b01; wa[0] = 5; wd[0] = 64'h1234;
    @(negedge clk);
    chk("wr_byp", rd1_b[0], 64'h1234);
    chk("wr_nobyp", rd1_n[0], 0);
    chk("r0_rd", rd1_b[1], 0);
    next_cyc(); wvalid = '0;
    @(negedge clk);
    chk("wr_next", rd1_n[0], 64'h1234);

    // both ports write r7, port 1 wins
    next_cyc(); wvalid = 2'b11; wa[0] = 7; wa[1] = 7; wd[0] = 64'hAA; wd[1] = 64'hBB;
    @(negedge clk);
    chk("merge_byp", rd2_b[0], 64'hBB);
    next_cyc(); wvalid = '0;
    @(negedge clk);
    chk("merge_next", rd2_n[0], 64'hBB);
    chk("merge_busy", rbusy2_b[0], 0);

    // issue r3 then writeback three cycles later
    next_cyc(); iss_valid = 1'b1; iss_addr[0] = 3;
    @(negedge clk);
    chk("iss_c1_busy", rbusy2_b[1], 0);
    chk("iss_c1_ready", iss_ready_b[0], 1);
    next_cyc(); iss_valid = 1'b0;
    @(negedge clk);
    chk("iss_c2_busy_b", rbusy2_b[1], 1);
    chk("iss_c2_busy_n", rbusy2_n[1], 1);
    next_cyc();
    next_cyc(); wvalid = 2'b01; wa[0] = 3; wd[0] = 64'h33;
    @(negedge clk);
    chk("wb_c4_b", rbusy2_b[1], 0);
    chk("wb_c4_n", rbusy2_n[1], 1);
    next_cyc(); wvalid = '0;
    @(negedge clk);
    chk("wb_c5_n", rbusy2_n[1], 0);
    chk("wb_c5_data", rd2_n[1], 64'h33);

    // fill r9 to saturation
    for (int i = 0; i < 3; i++) begin
      next_cyc(); iss_valid = 1'b1; iss_addr[0] = 9;
      @(negedge clk);
      chk("r9_ready", iss_ready_b[0], 1);
    end
    next_cyc();
    @(negedge clk);
    chk("r9_full", iss_ready_b[0], 0);
    next_cyc(); iss_valid = 1'b0; wvalid = 2'b01; wa[0] = 9; wd[0] = 64'h99;
    @(negedge clk);
    chk("r9_wb_ready", iss_ready_n[0], 0);
    next_cyc(); wvalid = '0; ra1[0] = 9;
    @(negedge clk);
    chk("r9_after_ready", iss_ready_n[0], 1);
    chk("r9_after_busy", rbusy1_b[0], 1);

    // issue + writeback r4 in the same cycle with cnt=1
    next_cyc(); iss_valid = 1'b1; iss_addr[0] = 4; ra1[1] = 4;
    next_cyc(); wvalid = 2'b01; wa[0] = 4; wd[0] = 64'h44;
    @(negedge clk);
    chk("r4_same_b", rbusy1_b[1], 0);
    chk("r4_same_n", rbusy1_n[1], 1);
    chk("r4_byp", rd1_b[1], 64'h44);
    next_cyc(); iss_valid = 1'b0; wvalid = '0;
    @(negedge clk);
    chk("r4_cnt", rbusy1_n[1], 1);
    chk("r4_data", rd1_n[1], 64'h44);

    // flush with r2=2, r6=1 pending and an r8 issue
    ra1[0] = 2; ra1[1] = 6; ra2[0] = 8; ra2[1] = 5;
    next_cyc(); iss_valid = 1'b1; iss_addr[0] = 2;
    next_cyc();
    next_cyc(); iss_addr[0] = 6;
    next_cyc(); iss_addr[0] = 8; flush = 1'b1;
    @(negedge clk);
    chk("fl_ready", iss_ready_b[0], 0);
    chk("fl_pre_busy", rbusy1_n[0], 1);
    next_cyc(); flush = 1'b0; iss_valid = 1'b0;
    @(negedge clk);
    chk("fl_r2", rbusy1_b[0], 0);
    chk("fl_r6", rbusy1_n[1], 0);
    chk("fl_r8", rbusy2_n[0], 0);
    chk("fl_data", rd2_n[1], 64'h1234);

    // same scenario with reset
    next_cyc(); iss_valid = 1'b1; iss_addr[0] = 2;
    next_cyc(); iss_addr[0] = 6;
    next_cyc(); iss_addr[0] = 8; reset = 1'b1; wvalid = 2'b01; wa[0] = 5; wd[0] = 64'h55;
    next_cyc(); reset = 1'b0; iss_valid = 1'b0; wvalid = '0;
    @(negedge clk);
    chk("rs_r2", rbusy1_n[0], 0);
    chk("rs_r6", rbusy1_n[1], 0);
    chk("rs_r8", rbusy2_n[0], 0);
    chk("rs_data", rd2_n[1], 0);
    chk("rs_ready", iss_ready_n[0], 1);

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      next_cyc();
      reset = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 29) == 0);
      for (int p = 0; p < 2; p++) begin
        ra1[p]    = rnd_addr();
        ra2[p]    = rnd_addr();
        wa[p]     = rnd_addr();
        wvalid[p] = ($urandom_range(0, 3) == 0);
        wd[p]     = {$urandom, $urandom};
      end
      iss_valid[0] = ($urandom_range(0, 2) != 0);
      iss_addr[0]  = rnd_addr();
    end
    next_cyc();
    reset = 1'b0; flush = 1'b0; wvalid = '0; iss_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
